// File: rtl/ieee754_to_int_pkg.sv
// Shared format constants, state/class encodings and operand classification
// for the float-to-integer converter.
package ieee754_to_int_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned INT_W   = 32;
  localparam int unsigned FRAC_W  = 0;

  localparam int unsigned F_W     = DATA_W - EXP_W - 1;
  localparam int unsigned MAN_W   = DATA_W - EXP_W;
  localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EXP_INF = (1 << EXP_W) - 1;
  localparam int unsigned MAG_W   = INT_W + 1;
  localparam int unsigned K_W     = $clog2(INT_W + MAN_W + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SHIFT,
    ST_ROUND
  } state_t;

  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_NAN,
    CLS_INF,
    CLS_ZERO
  } cls_t;

  // Classify the unsigned part (exponent + fraction) of a packed float.
  function automatic cls_t classify(input logic [DATA_W-2:0] body);
    logic [EXP_W-1:0] exp_f;
    logic [F_W-1:0]   frac_f;
    exp_f  = body[DATA_W-2:F_W];
    frac_f = body[F_W-1:0];
    if (exp_f == EXP_W'(EXP_INF))
      return (frac_f != '0) ? CLS_NAN : CLS_INF;
    else if (exp_f == '0 && frac_f == '0)
      return CLS_ZERO;
    else
      return CLS_NUM;
  endfunction

endpackage

// File: rtl/ieee754_to_int_if.sv
// Start/done pulse handshake plus operand and result bus of the converter.
interface ieee754_to_int_if;
  import ieee754_to_int_pkg::*;

  logic              start;
  logic [DATA_W-1:0] op;
  logic              busy;
  logic              done;
  logic [INT_W-1:0]  res;
  logic              overflow;
  logic              invalid;

  modport master (
    output start, op,
    input  busy, done, res, overflow, invalid
  );

  modport slave (
    input  start, op,
    output busy, done, res, overflow, invalid
  );

endinterface

// File: rtl/ieee754_to_int_round.sv
// Combinational round-to-nearest-even, saturation and sign application.
module ieee754_to_int_round
  import ieee754_to_int_pkg::*;
(
  input  logic             sign,
  input  logic [MAG_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic             force_nan,
  input  logic             force_ovf,
  input  logic             force_zero,
  output logic [INT_W-1:0] res,
  output logic             overflow,
  output logic             invalid
);

  localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [MAG_W:0]   LIM_POS = (MAG_W+1)'(SAT_POS);
  localparam logic [MAG_W:0]   LIM_NEG = (MAG_W+1)'(SAT_NEG);

  logic           inc;
  logic [MAG_W:0] rounded;
  logic [MAG_W:0] neg_rounded;

  // Round the magnitude, then pick forced, saturated or signed result.
  always_comb begin
    res         = '0;
    overflow    = 1'b0;
    invalid     = 1'b0;
    inc         = guard & (sticky | mag[0]);
    rounded     = (MAG_W+1)'(mag) + (MAG_W+1)'(inc);
    neg_rounded = -rounded;
    if (force_nan) begin
      res     = SAT_POS;
      invalid = 1'b1;
    end else if (force_ovf) begin
      res      = sign ? SAT_NEG : SAT_POS;
      overflow = 1'b1;
    end else if (force_zero) begin
      res = '0;
    end else if (!sign && rounded > LIM_POS) begin
      res      = SAT_POS;
      overflow = 1'b1;
    end else if (sign && rounded > LIM_NEG) begin
      res      = SAT_NEG;
      overflow = 1'b1;
    end else begin
      res = sign ? neg_rounded[INT_W-1:0] : rounded[INT_W-1:0];
    end
  end

endmodule

// File: rtl/ieee754_to_int.sv
// Multi-cycle IEEE-754 float to signed fixed-point converter, one shift
// step per cycle, start/done pulse handshake.
module ieee754_to_int
  import ieee754_to_int_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ieee754_to_int_if.slave    bus
);

  state_t            state;
  logic [DATA_W-1:0] op_q;
  logic              sign_q;
  logic [MAG_W-1:0]  mag_q;
  logic              guard_q;
  logic              sticky_q;
  logic              left_q;
  logic [K_W-1:0]    k_q;
  logic              f_nan_q;
  logic              f_ovf_q;
  logic              f_zero_q;
  logic              busy_q;
  logic              done_q;
  logic [INT_W-1:0]  res_q;
  logic              ovf_q;
  logic              inv_q;

  logic [EXP_W-1:0]  exp_c;
  logic [EXP_W-1:0]  eff_c;
  logic [MAN_W-1:0]  man_c;
  logic signed [31:0] sh_c;
  logic signed [31:0] nsh_c;
  logic [K_W-1:0]    k_c;
  logic              early_ovf_c;
  cls_t              cls_c;

  logic [INT_W-1:0]  rnd_res;
  logic              rnd_ovf;
  logic              rnd_inv;

  // Decode the latched operand into class, mantissa and shift amount.
  always_comb begin
    exp_c       = op_q[DATA_W-2:F_W];
    eff_c       = (exp_c == '0) ? EXP_W'(1) : exp_c;
    man_c       = {exp_c != '0, op_q[F_W-1:0]};
    cls_c       = classify(op_q[DATA_W-2:0]);
    sh_c        = $signed(32'(eff_c)) - $signed(32'(BIAS + MAN_W - 1))
                + $signed(32'(FRAC_W));
    nsh_c       = -sh_c;
    early_ovf_c = sh_c > $signed(32'(INT_W - MAN_W));
    k_c         = '0;
    if (!sh_c[31])
      k_c = K_W'(sh_c);
    else if (nsh_c > $signed(32'(MAN_W + 1)))
      k_c = K_W'(MAN_W + 1);
    else
      k_c = K_W'(nsh_c);
  end

  ieee754_to_int_round u_round (
    .sign       (sign_q),
    .mag        (mag_q),
    .guard      (guard_q),
    .sticky     (sticky_q),
    .force_nan  (f_nan_q),
    .force_ovf  (f_ovf_q),
    .force_zero (f_zero_q),
    .res        (rnd_res),
    .overflow   (rnd_ovf),
    .invalid    (rnd_inv)
  );

  // Control FSM with shift datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      left_q   <= 1'b0;
      k_q      <= '0;
      f_nan_q  <= 1'b0;
      f_ovf_q  <= 1'b0;
      f_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            busy_q <= 1'b1;
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          sign_q   <= op_q[DATA_W-1];
          guard_q  <= 1'b0;
          sticky_q <= 1'b0;
          mag_q    <= '0;
          left_q   <= 1'b0;
          k_q      <= '0;
          f_nan_q  <= 1'b0;
          f_ovf_q  <= 1'b0;
          f_zero_q <= 1'b0;
          state    <= ST_ROUND;
          case (cls_c)
            CLS_NAN:  f_nan_q  <= 1'b1;
            CLS_INF:  f_ovf_q  <= 1'b1;
            CLS_ZERO: f_zero_q <= 1'b1;
            default: begin
              if (early_ovf_c) begin
                f_ovf_q <= 1'b1;
              end else begin
                mag_q  <= MAG_W'(man_c);
                left_q <= ~sh_c[31];
                k_q    <= k_c;
                if (k_c != '0)
                  state <= ST_SHIFT;
              end
            end
          endcase
        end
        ST_SHIFT: begin
          // Right shifts feed the guard bit; the old guard folds into sticky.
          if (left_q) begin
            mag_q <= mag_q << 1;
          end else begin
            mag_q    <= mag_q >> 1;
            guard_q  <= mag_q[0];
            sticky_q <= sticky_q | guard_q;
          end
          k_q <= k_q - K_W'(1);
          if (k_q == K_W'(1))
            state <= ST_ROUND;
        end
        ST_ROUND: begin
          res_q  <= rnd_res;
          ovf_q  <= rnd_ovf;
          inv_q  <= rnd_inv;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.res      = res_q;
  assign bus.overflow = ovf_q;
  assign bus.invalid  = inv_q;

endmodule

// File: tb/tb_ieee754_to_int.sv
// Bench for ieee754_to_int: directed test-plan cases, randomized operands
// against a real-arithmetic reference, and handshake/reset scenarios.
module tb_ieee754_to_int;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ieee754_to_int_if bus_if ();

  ieee754_to_int dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: value of the float as a real, rounded half-to-even, saturated.
  task automatic model(input logic [31:0] op, output logic [31:0] r,
                       output logic o, output logic inv, output int lat);
    int     e, f, eff, sh, k, mant;
    real    v, fr;
    longint ri;
    logic   s;
    s   = op[31];
    e   = int'(op[30:23]);
    f   = int'(op[22:0]);
    o   = 1'b0;
    inv = 1'b0;
    eff = (e == 0) ? 1 : e;
    sh  = eff - 127 - 23;
    if (e == 255) begin
      lat = 3;
      if (f != 0) begin
        r = 32'h7FFFFFFF; inv = 1'b1;
      end else begin
        r = s ? 32'h80000000 : 32'h7FFFFFFF; o = 1'b1;
      end
      return;
    end
    if ((e == 0 && f == 0) || sh > 8) begin
      lat = 3;
    end else begin
      k   = (sh >= 0) ? sh : ((-sh > 25) ? 25 : -sh);
      lat = k + 3;
    end
    mant = (e != 0) ? (f + (1 << 23)) : f;
    v    = real'(mant) * (2.0 ** real'(sh));
    if (s) v = -v;
    if (v >= 2.0 ** 40) begin
      r = 32'h7FFFFFFF; o = 1'b1;
    end else if (v <= -(2.0 ** 40)) begin
      r = 32'h80000000; o = 1'b1;
    end else begin
      ri = longint'($floor(v));
      fr = v - real'(ri);
      if (fr > 0.5 || (fr == 0.5 && ri[0])) ri = ri + 1;
      if (ri > 64'sd2147483647) begin
        r = 32'h7FFFFFFF; o = 1'b1;
      end else if (ri < -64'sd2147483648) begin
        r = 32'h80000000; o = 1'b1;
      end else begin
        r = ri[31:0];
      end
    end
  endtask

  // Pulse start at the current falling edge; return at the done cycle.
  task automatic run_conv(input logic [31:0] op, output logic [31:0] r,
                          output logic o, output logic inv,
                          output int lat, output logic busy1);
    bus_if.op    = op;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat   = 1;
    busy1 = bus_if.busy;
    while (bus_if.done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 64) lat = -1;
    r   = bus_if.res;
    o   = bus_if.overflow;
    inv = bus_if.invalid;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.overflow, bus_if.invalid} !== 4'b0 ||
        bus_if.res !== 32'h0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b res=%h ovf=%b inv=%b, required all 0",
               bus_if.busy, bus_if.done, bus_if.res, bus_if.overflow, bus_if.invalid);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ops  [12] = '{32'h40490FDB, 32'h3FC00000, 32'h40200000, 32'hC0200000,
                               32'h4F000000, 32'hCF000000, 32'h5F000000, 32'h7FC00000,
                               32'hFF800000, 32'h80000000, 32'h00000001, 32'h7F800000};
    logic [31:0] eres [12] = '{32'd3, 32'd2, 32'd2, 32'hFFFFFFFE,
                               32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF,
                               32'h80000000, 32'h0, 32'h0, 32'h7FFFFFFF};
    logic        eovf [12] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    logic        einv [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int          elat [12] = '{25, 26, 25, 25, 11, 11, 3, 3, 3, 3, 28, 3};
    logic [31:0] r;
    logic        o, inv, b1;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      run_conv(ops[i], r, o, inv, lat, b1);
      checks++;
      if (r !== eres[i] || o !== eovf[i] || inv !== einv[i]) begin
        failures++;
        $display("FAIL directed_result op=%h got res=%h ovf=%b inv=%b required res=%h ovf=%b inv=%b",
                 ops[i], r, o, inv, eres[i], eovf[i], einv[i]);
      end
      checks++;
      if (lat != elat[i] || b1 !== 1'b1) begin
        failures++;
        $display("FAIL directed_latency op=%h got lat=%0d busy1=%b required lat=%0d busy1=1",
                 ops[i], lat, b1, elat[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] op, r, er;
    logic        o, inv, eo, einv, b1;
    int          lat, elat, e, f;
    for (int i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(110, 165);
      f = $urandom_range(0, (1 << 23) - 1);
      if ($urandom_range(0, 3) == 0) f = f & ~((1 << $urandom_range(0, 22)) - 1);
      op = {1'($urandom_range(0, 1)), 8'(e), 23'(f)};
      model(op, er, eo, einv, elat);
      run_conv(op, r, o, inv, lat, b1);
      checks++;
      if (r !== er || o !== eo || inv !== einv || lat != elat) begin
        failures++;
        $display("FAIL random op=%h got res=%h ovf=%b inv=%b lat=%0d required res=%h ovf=%b inv=%b lat=%0d",
                 op, r, o, inv, lat, er, eo, einv, elat);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] prev;
    int          lat;
    logic        changed;
    prev         = bus_if.res;
    changed      = 1'b0;
    bus_if.op    = 32'h40490FDB;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat = 1;
    while (bus_if.done !== 1'b1 && lat < 64) begin
      if (bus_if.res !== prev) changed = 1'b1;
      if (lat == 5) begin bus_if.start = 1'b1; bus_if.op = 32'h3FC00000; end
      if (lat == 6) bus_if.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (changed) begin
      failures++;
      $display("FAIL ignored_start_res_held res changed before done, required held at %h", prev);
    end
    checks++;
    if (bus_if.res !== 32'd3 || lat != 25) begin
      failures++;
      $display("FAIL ignored_start got res=%h lat=%0d required res=00000003 lat=25",
               bus_if.res, lat);
    end
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start_idle busy=%b required 0", bus_if.busy);
    end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    bus_if.op    = 32'h40490FDB;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.overflow, bus_if.invalid} !== 4'b0 ||
        bus_if.res !== 32'h0) begin
      failures++;
      $display("FAIL reset_abort busy=%b done=%b res=%h ovf=%b inv=%b required all 0",
               bus_if.busy, bus_if.done, bus_if.res, bus_if.overflow, bus_if.invalid);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_abort_no_done activity after reset got 1 required 0");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic        o, inv, b1;
    int          lat;
    run_conv(32'h4F000000, r, o, inv, lat, b1);
    checks++;
    if (r !== 32'h7FFFFFFF || o !== 1'b1 || lat != 11) begin
      failures++;
      $display("FAIL b2b_first got res=%h ovf=%b lat=%0d required res=7fffffff ovf=1 lat=11",
               r, o, lat);
    end
    run_conv(32'hC0200000, r, o, inv, lat, b1);
    checks++;
    if (r !== 32'hFFFFFFFE || o !== 1'b0 || inv !== 1'b0 || lat != 25 || b1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got res=%h ovf=%b inv=%b lat=%0d busy1=%b required res=fffffffe ovf=0 inv=0 lat=25 busy1=1",
               r, o, inv, lat, b1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
